// File: rtl/gmii_rx_parser.sv
// gmii_rx_parser: GMII receive parser; checks Ethernet/IPv4/UDP/app header, unpacks video words / audio samples.
// Latency: one cycle from the last byte of a word/sample (or b45, or rx_dv low in TAIL) to the registered output.
// Backpressure: none toward GMII; a write into a full FIFO loses the word, flags the frame bad, assembly continues.
// Ports: rx_clk/sys_rst_n clock and async active-low reset; rx_dv/rx_er/rxd GMII input; id expected source id;
//        vid_dout/vid_wr_en/vid_full and aud_dout/aud_wr_en/aud_full FIFO write sides;
//        line_y, frame_start, frame_ok, drop_cnt frame status.
module gmii_rx_parser #(
  parameter logic [15:0] DST_PORT = 16'd12345,
  parameter int          CNT_W    = 16
) (
  input  logic             rx_clk,
  input  logic             sys_rst_n,
  input  logic             rx_dv,
  input  logic             rx_er,
  input  logic [7:0]       rxd,
  input  logic             id,
  output logic [47:0]      vid_dout,
  output logic             vid_wr_en,
  input  logic             vid_full,
  output logic [11:0]      aud_dout,
  output logic             aud_wr_en,
  input  logic             aud_full,
  output logic [10:0]      line_y,
  output logic             frame_start,
  output logic             frame_ok,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_PAY, S_TAIL, S_SKIP} state_t;

  state_t             state_q, state_d;
  logic [5:0]         b_q, b_d;           // header byte index after SFD
  logic [15:0]        len_q, len_d;       // UDP length
  logic               kind_q, kind_d;     // 0 video, 1 audio
  logic [2:0]         line_hi_q, line_hi_d;
  logic [15:0]        rem_q, rem_d;       // payload bytes still to consume
  logic [2:0]         sub_q, sub_d;       // byte position inside word/sample
  logic [39:0]        vsr_q, vsr_d;       // first five bytes of the video word
  logic [3:0]         ahi_q, ahi_d;       // low nibble of the first audio byte
  logic               bad_q, bad_d;       // frame lost a word to a full FIFO
  logic [47:0]        vid_dout_q, vid_dout_d;
  logic               vid_wr_en_q, vid_wr_en_d;
  logic [11:0]        aud_dout_q, aud_dout_d;
  logic               aud_wr_en_q, aud_wr_en_d;
  logic [10:0]        line_y_q, line_y_d;
  logic               frame_start_q, frame_start_d;
  logic               frame_ok_q, frame_ok_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic [15:0]        plen;
  logic               hdr_fail;
  logic               hdr_accept;
  logic               drop_inc;

  assign plen = len_q - 16'd12;

  // Per-byte header checks; length/kind legality is resolved on the last header byte.
  always_comb begin
    hdr_fail = 1'b0;
    case (b_q)
      6'd12:   hdr_fail = (rxd != 8'h08);
      6'd13:   hdr_fail = (rxd != 8'h00);
      6'd23:   hdr_fail = (rxd != 8'h11);
      6'd36:   hdr_fail = (rxd != DST_PORT[15:8]);
      6'd37:   hdr_fail = (rxd != DST_PORT[7:0]);
      6'd42:   hdr_fail = (rxd[0] != id);
      6'd43:   hdr_fail = (rxd > 8'h01);
      6'd45:   hdr_fail = (len_q < 16'd12) ||
                          (!kind_q && ((plen % 16'd6) != 16'd0)) ||
                          (kind_q && len_q[0]);
      default: hdr_fail = 1'b0;
    endcase
  end

  assign hdr_accept = (state_q == S_HDR) && rx_dv && !rx_er && !hdr_fail && (b_q == 6'd45);

  // State register
  always_ff @(posedge rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (rx_dv) state_d = (rxd == 8'h55) ? S_PRE : S_SKIP;
      S_PRE: begin
        if (!rx_dv)              state_d = S_IDLE;
        else if (rx_er)          state_d = S_SKIP;
        else if (rxd == 8'hD5)   state_d = S_HDR;
        else if (rxd != 8'h55)   state_d = S_SKIP;
      end
      S_HDR: begin
        if (!rx_dv)              state_d = S_IDLE;
        else if (rx_er)          state_d = S_SKIP;
        else if (hdr_fail)       state_d = S_SKIP;
        else if (b_q == 6'd45)   state_d = (plen == 16'd0) ? S_TAIL : S_PAY;
      end
      S_PAY: begin
        if (!rx_dv)              state_d = S_IDLE;
        else if (rx_er)          state_d = S_SKIP;
        else if (rem_q == 16'd1) state_d = S_TAIL;
      end
      S_TAIL: begin
        if (!rx_dv)              state_d = S_IDLE;
        else if (rx_er)          state_d = S_SKIP;
      end
      S_SKIP: if (!rx_dv) state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  // Every return to IDLE except a clean TAIL completion counts as a drop.
  assign drop_inc = (state_q != S_IDLE) && (state_d == S_IDLE) && !((state_q == S_TAIL) && !bad_q);

  // Output / datapath next-state logic
  always_comb begin
    b_d           = b_q;
    len_d         = len_q;
    kind_d        = kind_q;
    line_hi_d     = line_hi_q;
    rem_d         = rem_q;
    sub_d         = sub_q;
    vsr_d         = vsr_q;
    ahi_d         = ahi_q;
    bad_d         = bad_q;
    vid_dout_d    = vid_dout_q;
    vid_wr_en_d   = 1'b0;
    aud_dout_d    = aud_dout_q;
    aud_wr_en_d   = 1'b0;
    line_y_d      = line_y_q;
    frame_start_d = 1'b0;
    frame_ok_d    = 1'b0;
    drop_cnt_d    = drop_cnt_q;
    case (state_q)
      S_PRE: b_d = '0;
      S_HDR: begin
        if (rx_dv && !rx_er) begin
          b_d = b_q + 6'd1;
          case (b_q)
            6'd38:   len_d[15:8] = rxd;
            6'd39:   len_d[7:0]  = rxd;
            6'd43:   kind_d      = rxd[0];
            6'd44:   line_hi_d   = rxd[2:0];
            default: ;
          endcase
          if (hdr_accept) begin
            line_y_d      = {line_hi_q, rxd};
            frame_start_d = 1'b1;
            rem_d         = plen;
            sub_d         = '0;
            bad_d         = 1'b0;
          end
        end
      end
      S_PAY: begin
        if (rx_dv && !rx_er) begin
          rem_d = rem_q - 16'd1;
          if (!kind_q) begin
            if (sub_q == 3'd5) begin
              vid_dout_d = {vsr_q, rxd};
              sub_d      = '0;
              if (vid_full) bad_d       = 1'b1;
              else          vid_wr_en_d = 1'b1;
            end else begin
              vsr_d = {vsr_q[31:0], rxd};
              sub_d = sub_q + 3'd1;
            end
          end else begin
            if (sub_q == 3'd0) begin
              ahi_d = rxd[3:0];
              sub_d = 3'd1;
            end else begin
              aud_dout_d = {ahi_q, rxd};
              sub_d      = '0;
              if (aud_full) bad_d       = 1'b1;
              else          aud_wr_en_d = 1'b1;
            end
          end
        end
      end
      S_TAIL: if (!rx_dv && !bad_q) frame_ok_d = 1'b1;
      default: ;
    endcase
    if (drop_inc && !(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      b_q           <= '0;
      len_q         <= '0;
      kind_q        <= 1'b0;
      line_hi_q     <= '0;
      rem_q         <= '0;
      sub_q         <= '0;
      vsr_q         <= '0;
      ahi_q         <= '0;
      bad_q         <= 1'b0;
      vid_dout_q    <= '0;
      vid_wr_en_q   <= 1'b0;
      aud_dout_q    <= '0;
      aud_wr_en_q   <= 1'b0;
      line_y_q      <= '0;
      frame_start_q <= 1'b0;
      frame_ok_q    <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      b_q           <= b_d;
      len_q         <= len_d;
      kind_q        <= kind_d;
      line_hi_q     <= line_hi_d;
      rem_q         <= rem_d;
      sub_q         <= sub_d;
      vsr_q         <= vsr_d;
      ahi_q         <= ahi_d;
      bad_q         <= bad_d;
      vid_dout_q    <= vid_dout_d;
      vid_wr_en_q   <= vid_wr_en_d;
      aud_dout_q    <= aud_dout_d;
      aud_wr_en_q   <= aud_wr_en_d;
      line_y_q      <= line_y_d;
      frame_start_q <= frame_start_d;
      frame_ok_q    <= frame_ok_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign vid_dout    = vid_dout_q;
  assign vid_wr_en   = vid_wr_en_q;
  assign aud_dout    = aud_dout_q;
  assign aud_wr_en   = aud_wr_en_q;
  assign line_y      = line_y_q;
  assign frame_start = frame_start_q;
  assign frame_ok    = frame_ok_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_gmii_rx_parser.sv
// tb_gmii_rx_parser: scoreboard bench for gmii_rx_parser with directed frames.
// Expected words/samples/line numbers are queued by the stimulus; a monitor pops them on each output strobe.
module tb_gmii_rx_parser;

  localparam logic [15:0] DST = 16'd12345;

  logic        rx_clk = 1'b0;
  logic        sys_rst_n;
  logic        rx_dv, rx_er, id;
  logic [7:0]  rxd;
  logic [47:0] vid_dout;
  logic        vid_wr_en, vid_full;
  logic [11:0] aud_dout;
  logic        aud_wr_en, aud_full;
  logic [10:0] line_y;
  logic        frame_start, frame_ok;
  logic [15:0] drop_cnt;

  gmii_rx_parser #(.DST_PORT(DST), .CNT_W(16)) dut (
    .rx_clk(rx_clk), .sys_rst_n(sys_rst_n), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd), .id(id),
    .vid_dout(vid_dout), .vid_wr_en(vid_wr_en), .vid_full(vid_full),
    .aud_dout(aud_dout), .aud_wr_en(aud_wr_en), .aud_full(aud_full),
    .line_y(line_y), .frame_start(frame_start), .frame_ok(frame_ok), .drop_cnt(drop_cnt)
  );

  always #4 rx_clk = ~rx_clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_cyc = 0;
  int ok_seen = 0;
  int exp_ok = 0;
  int exp_drop = 0;
  logic [10:0] exp_line_y = '0;

  logic [47:0] exp_vid[$];
  logic [11:0] exp_aud[$];
  logic [10:0] exp_line[$];
  logic [7:0]  frm[$];

  always @(posedge rx_clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops and compares whenever the DUT presents an output event.
  always @(negedge rx_clk) begin
    if (sys_rst_n === 1'b1) begin
      if (frame_start) begin
        if (exp_line.size() == 0) check("unexpected_frame_start", 64'(line_y), 64'h7FF_DEAD);
        else check("line_y_at_start", 64'(line_y), 64'(exp_line.pop_front()));
        last_cyc = cyc;
      end
      if (vid_wr_en) begin
        if (exp_vid.size() == 0) check("unexpected_vid_wr", 64'(vid_dout), 64'hDEAD_0000_0000_0000);
        else check("vid_dout", 64'(vid_dout), 64'(exp_vid.pop_front()));
        check("vid_spacing", 64'(cyc - last_cyc), 64'd6);
        last_cyc = cyc;
      end
      if (aud_wr_en) begin
        if (exp_aud.size() == 0) check("unexpected_aud_wr", 64'(aud_dout), 64'hDEAD_0000);
        else check("aud_dout", 64'(aud_dout), 64'(exp_aud.pop_front()));
        check("aud_spacing", 64'(cyc - last_cyc), 64'd2);
        last_cyc = cyc;
      end
      if (frame_ok) ok_seen = ok_seen + 1;
    end
  end

  task automatic build_hdr(input logic [15:0] port, input logic idb, input logic [7:0] kind,
                           input logic [10:0] line, input logic [15:0] len);
    logic [7:0] v;
    frm.delete();
    repeat (7) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    for (int b = 0; b < 46; b++) begin
      case (b)
        12: v = 8'h08;
        13: v = 8'h00;
        23: v = 8'h11;
        36: v = port[15:8];
        37: v = port[7:0];
        38: v = len[15:8];
        39: v = len[7:0];
        42: v = {7'b1010100, idb};
        43: v = kind;
        44: v = {5'b10101, line[10:8]};
        45: v = line[7:0];
        default: v = 8'h60 + 8'(b);
      endcase
      frm.push_back(v);
    end
  endtask

  task automatic add_fcs();
    frm.push_back(8'hC1); frm.push_back(8'hC2); frm.push_back(8'hC3); frm.push_back(8'hC4);
  endtask

  task automatic add_bytes(input logic [95:0] data, input int n);
    for (int i = n - 1; i >= 0; i--) frm.push_back(data[i*8 +: 8]);
  endtask

  // Drives frm[0 .. cut-1], asserting rx_er on index er, then one idle cycle plus a gap.
  task automatic send(input int er, input int cut);
    for (int i = 0; i < frm.size() && i < cut; i++) begin
      @(posedge rx_clk); #1;
      rx_dv = 1'b1; rxd = frm[i]; rx_er = (i == er);
    end
    @(posedge rx_clk); #1;
    rx_dv = 1'b0; rx_er = 1'b0; rxd = 8'h00;
    repeat (10) @(posedge rx_clk);
    #1;
  endtask

  task automatic accept_line(input logic [10:0] l);
    exp_line.push_back(l);
    exp_line_y = l;
  endtask

  task automatic checkpoint(input string tag);
    check({tag, "_frame_ok_count"}, 64'(ok_seen), 64'(exp_ok));
    check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
    check({tag, "_line_y"}, 64'(line_y), 64'(exp_line_y));
    check({tag, "_vid_pending"}, 64'(exp_vid.size()), 64'd0);
    check({tag, "_aud_pending"}, 64'(exp_aud.size()), 64'd0);
    check({tag, "_start_pending"}, 64'(exp_line.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n = 1'b0; rx_dv = 1'b0; rx_er = 1'b0; rxd = 8'h00; id = 1'b1;
    vid_full = 1'b0; aud_full = 1'b0;
    repeat (3) @(posedge rx_clk);
    #1;
    check("rst_vid_dout", 64'(vid_dout), 64'd0);
    check("rst_aud_dout", 64'(aud_dout), 64'd0);
    check("rst_strobes", 64'({vid_wr_en, aud_wr_en, frame_start, frame_ok}), 64'd0);
    check("rst_line_y", 64'(line_y), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    sys_rst_n = 1'b1;
    repeat (2) @(posedge rx_clk);
    #1;

    // Valid two-word video frame
    build_hdr(DST, 1'b1, 8'h00, 11'h123, 16'd24);
    add_bytes(96'h0102030405060708090A0B0C, 12); add_fcs();
    accept_line(11'h123);
    exp_vid.push_back(48'h010203040506); exp_vid.push_back(48'h0708090A0B0C);
    exp_ok++;
    send(-1, 1000);
    checkpoint("video");

    // Valid audio frame
    build_hdr(DST, 1'b1, 8'h01, 11'h045, 16'd16);
    add_bytes(96'hFABC0123, 4); add_fcs();
    accept_line(11'h045);
    exp_aud.push_back(12'hABC); exp_aud.push_back(12'h123);
    exp_ok++;
    send(-1, 1000);
    checkpoint("audio");

    // Wrong port, wrong id, bad kind
    build_hdr(DST + 16'd1, 1'b1, 8'h00, 11'h111, 16'd24);
    add_bytes(96'h0102030405060708090A0B0C, 12); add_fcs();
    send(-1, 1000);
    build_hdr(DST, 1'b0, 8'h00, 11'h222, 16'd24);
    add_bytes(96'h0102030405060708090A0B0C, 12); add_fcs();
    send(-1, 1000);
    build_hdr(DST, 1'b1, 8'h02, 11'h333, 16'd24);
    add_bytes(96'h0102030405060708090A0B0C, 12); add_fcs();
    send(-1, 1000);
    exp_drop += 3;
    checkpoint("hdr_drops");

    // rx_dv falls after 4 bytes of the second word
    build_hdr(DST, 1'b1, 8'h00, 11'h1F0, 16'd24);
    add_bytes(96'hA1A2A3A4A5A6B1B2B3B4B5B6, 12); add_fcs();
    accept_line(11'h1F0);
    exp_vid.push_back(48'hA1A2A3A4A5A6);
    exp_drop++;
    send(-1, 64);
    checkpoint("cut");
    build_hdr(DST, 1'b1, 8'h00, 11'h200, 16'd24);
    add_bytes(96'h112233445566778899AABBCC, 12); add_fcs();
    accept_line(11'h200);
    exp_vid.push_back(48'h112233445566); exp_vid.push_back(48'h778899AABBCC);
    exp_ok++;
    send(-1, 1000);
    checkpoint("after_cut");

    // rx_er at b20, then a frame written into a full video FIFO
    build_hdr(DST, 1'b1, 8'h00, 11'h300, 16'd24);
    add_bytes(96'h0102030405060708090A0B0C, 12); add_fcs();
    exp_drop++;
    send(28, 1000);
    checkpoint("rx_er");
    build_hdr(DST, 1'b1, 8'h00, 11'h0F0, 16'd24);
    add_bytes(96'h0102030405060708090A0B0C, 12); add_fcs();
    accept_line(11'h0F0);
    exp_drop++;
    vid_full = 1'b1;
    send(-1, 1000);
    vid_full = 1'b0;
    checkpoint("vid_full");

    // Length boundaries: L<12, video P=8, audio P=3, then video P=0 accepted
    build_hdr(DST, 1'b1, 8'h00, 11'h010, 16'd10); add_fcs();
    send(-1, 1000);
    build_hdr(DST, 1'b1, 8'h00, 11'h020, 16'd20);
    add_bytes(96'h0102030405060708, 8); add_fcs();
    send(-1, 1000);
    build_hdr(DST, 1'b1, 8'h01, 11'h030, 16'd15);
    add_bytes(96'h010203, 3); add_fcs();
    send(-1, 1000);
    exp_drop += 3;
    build_hdr(DST, 1'b1, 8'h00, 11'h7FF, 16'd12); add_fcs();
    accept_line(11'h7FF);
    exp_ok++;
    send(-1, 1000);
    checkpoint("length");

    // Reset mid-payload
    build_hdr(DST, 1'b1, 8'h00, 11'h3AB, 16'd24);
    add_bytes(96'h0102030405060708090A0B0C, 12); add_fcs();
    accept_line(11'h3AB);
    for (int i = 0; i < 57; i++) begin
      @(posedge rx_clk); #1;
      rx_dv = 1'b1; rxd = frm[i];
    end
    @(posedge rx_clk); #1;
    sys_rst_n = 1'b0;
    #1;
    check("midrst_line_y", 64'(line_y), 64'd0);
    check("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("midrst_vid_dout", 64'(vid_dout), 64'd0);
    check("midrst_strobes", 64'({vid_wr_en, aud_wr_en, frame_start, frame_ok}), 64'd0);
    exp_drop = 0;
    exp_line_y = '0;
    repeat (3) @(posedge rx_clk);
    #1;
    sys_rst_n = 1'b1;
    // Frame missing its preamble goes through SKIP
    build_hdr(DST, 1'b1, 8'h00, 11'h055, 16'd24);
    add_bytes(96'h0102030405060708090A0B0C, 12); add_fcs();
    repeat (8) void'(frm.pop_front());
    rx_dv = 1'b0;
    exp_drop++;
    send(-1, 1000);
    checkpoint("no_preamble");
    build_hdr(DST, 1'b1, 8'h01, 11'h066, 16'd14);
    add_bytes(96'h5E7F, 2); add_fcs();
    accept_line(11'h066);
    exp_aud.push_back(12'hE7F);
    exp_ok++;
    send(-1, 1000);
    checkpoint("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
